// File: rtl/key_event_ctrl_pkg.sv
// Key event controller shared types and defaults.
// Channel state encoding plus debounce/long-press timing constants.
package key_event_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } chan_state_e;

  localparam int DEB_T_DEF  = 100000;
  localparam int LONG_T_DEF = 25000000;
  localparam int KEY_W_DEF  = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event queue handshake between the key controller and its consumer.
// Show-ahead head entry: valid/key/long with a ready back-pressure.
interface key_event_ctrl_if
  import key_event_ctrl_pkg::*;
#(
  parameter int KW = KEY_W_DEF
);
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic          evt_long;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_long,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_long,
    output evt_ready
  );
endinterface

// File: rtl/key_event_ctrl_chan.sv
// Per-key debounce and hold-time channel.
// Completes one event per debounced press/release and holds it pending.
module key_chan
  import key_event_ctrl_pkg::*;
#(
  parameter int DEB_T  = DEB_T_DEF,
  parameter int LONG_T = LONG_T_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  input  logic grant_i,
  output logic pend_o,
  output logic long_o,
  output logic lost_o
);

  localparam int DW = $clog2(DEB_T + 1);
  localparam int HW = $clog2(LONG_T + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_T - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_T);

  chan_state_e   st_q;
  logic [DW-1:0] deb_q;
  logic [HW-1:0] hold_q;
  logic          pend_q;
  logic          long_q;
  logic          done;

  assign done   = (st_q == REL_DEB) && key_n_i && (deb_q == DEB_LAST);
  assign lost_o = done && pend_q;
  assign pend_o = pend_q;
  assign long_o = long_q;

  // debounce/hold state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      deb_q  <= '0;
      hold_q <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (!key_n_i) begin
            st_q  <= PRESS_DEB;
            deb_q <= '0;
          end
        end
        PRESS_DEB: begin
          if (key_n_i) begin
            st_q <= IDLE;
          end else if (deb_q == DEB_LAST) begin
            st_q   <= HELD;
            hold_q <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        HELD: begin
          if (hold_q < HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
          end
          if (key_n_i) begin
            st_q  <= REL_DEB;
            deb_q <= '0;
          end
        end
        REL_DEB: begin
          if (!key_n_i) begin
            st_q <= HELD;
          end else if (deb_q == DEB_LAST) begin
            st_q <= IDLE;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // pending slot: a completion while occupied is dropped (lost_o)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      long_q <= 1'b0;
    end else if (grant_i) begin
      pend_q <= 1'b0;
    end else if (done && !pend_q) begin
      pend_q <= 1'b1;
      long_q <= (hold_q >= HOLD_MAX);
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key channels, round-robin arbiter, event FIFO.
// Sticky overflow flags any event dropped behind a still-pending one.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int DEB_T      = DEB_T_DEF,
  parameter int LONG_T     = LONG_T_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  key_event_ctrl_if.master  evt,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int KW = idx_w(N_KEYS);
  localparam int PW = idx_w(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [N_KEYS-1:0] pend;
  logic [N_KEYS-1:0] long_v;
  logic [N_KEYS-1:0] lost;
  logic [N_KEYS-1:0] grant;

  logic [KW-1:0] rr_q;
  logic          hi_vld;
  logic [KW-1:0] hi_idx;
  logic          lo_vld;
  logic [KW-1:0] lo_idx;
  logic [KW-1:0] gnt_idx;
  logic          push;
  logic          pop;
  logic          valid_w;

  logic [FIFO_DEPTH-1:0][KW:0] mem_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ovf_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .DEB_T  (DEB_T),
      .LONG_T (LONG_T)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n_i (key_n[g]),
      .grant_i (grant[g]),
      .pend_o  (pend[g]),
      .long_o  (long_v[g]),
      .lost_o  (lost[g])
    );
  end

  // round-robin pick: lowest pending above rr_q, else lowest overall
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        if (i > int'(rr_q)) begin
          hi_vld = 1'b1;
          hi_idx = KW'(i);
        end
        lo_vld = 1'b1;
        lo_idx = KW'(i);
      end
    end
  end

  assign gnt_idx = hi_vld ? hi_idx : lo_idx;
  assign push    = lo_vld && (cnt_q != CW'(FIFO_DEPTH));
  assign valid_w = (cnt_q != '0);
  assign pop     = valid_w && evt.evt_ready;

  // one-hot grant back to the winning channel
  always_comb begin
    grant = '0;
    if (push) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {gnt_idx, long_v[gnt_idx]};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  // last granted index for round-robin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= KW'(N_KEYS - 1);
    end else if (push) begin
      rr_q <= gnt_idx;
    end
  end

  // sticky overflow; a new loss wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (|lost) begin
      ovf_q <= 1'b1;
    end else if (clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign evt.evt_valid = valid_w;
  assign evt.evt_key   = mem_q[rd_q][KW:1];
  assign evt.evt_long  = mem_q[rd_q][0];
  assign overflow      = ovf_q;

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of raw key inputs.
REQ-002 SHALL have parameter DEB_T, default 100000, debounce interval in clk cycles.
REQ-003 SHALL have parameter LONG_T, default 25000000, minimum hold cycles for a long press.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two).
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_n  input  N_KEYS  raw keys, active-low, pre-synchronized by the caller.
REQ-008 evt_valid  output  1  queue head holds a valid event.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_key  output  clog2(N_KEYS)  key index of the head event.
REQ-011 evt_long  output  1  head event is a long press.
REQ-012 overflow  output  1  sticky flag: an event was lost.
REQ-013 clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 Each key SHALL have one channel FSM with states IDLE, PRESS_DEB, HELD, REL_DEB, a debounce counter, and a hold counter.
REQ-015 IDLE: key_n low -> PRESS_DEB with debounce counter 0; otherwise stay.
REQ-016 PRESS_DEB: key_n high -> IDLE; counter = DEB_T-1 with key low -> HELD with hold counter 0; otherwise increment.
REQ-017 HELD: hold counter increments and saturates at LONG_T; key_n high -> REL_DEB with debounce counter 0.
REQ-018 REL_DEB: key_n low -> HELD without clearing the hold counter; counter = DEB_T-1 with key high -> IDLE and event completion.
REQ-019 On event completion the channel SHALL set pending and latch long = (hold counter >= LONG_T).
REQ-020 If completion occurs while pending is still set, the new event SHALL be dropped, the old one kept, and overflow set.
REQ-021 The arbiter SHALL grant at most one pending channel per cycle, only when the FIFO count < FIFO_DEPTH; registered count, same-cycle pop not considered.
REQ-022 Grant order SHALL be round-robin, searching from last granted index +1 with wrap to 0; the pointer after reset is N_KEYS-1, so key 0 has first priority.
REQ-023 A grant SHALL clear that channel's pending and push {index, long} into the FIFO on the same edge.
REQ-024 FIFO SHALL be show-ahead: evt_valid = count != 0; evt_key/evt_long reflect the head entry.
REQ-025 Pop SHALL occur on evt_valid && evt_ready; simultaneous push and pop leaves count unchanged.
REQ-026 Latency: completion at edge E sets pending; the grant at E+1 pushes; an empty FIFO shows evt_valid after E+1.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 overflow SHALL clear on clear_ovf; if clear_ovf coincides with a new loss, overflow SHALL end set.
REQ-029 Pending events SHALL wait and SHALL NOT be lost while the FIFO is full.

Reset
REQ-030 Reset SHALL set all channels to IDLE, all counters to 0, pending and long to 0, FIFO count and pointers to 0, evt_valid 0, overflow 0, and the round-robin pointer to N_KEYS-1.
REQ-031 Reset mid-press SHALL discard the in-progress event; after release, a key held low SHALL restart at PRESS_DEB.

Structure
REQ-032 A shared package SHALL hold the channel-state enum and the default DEB_T/LONG_T constants.
REQ-033 The per-key FSM SHALL be sub-module key_chan, instantiated N_KEYS times; the arbiter and FIFO SHALL be in key_event_ctrl.

Verification (DEB_T=4, LONG_T=20, N_KEYS=4, FIFO_DEPTH=4)
REQ-034 Key 2 low for 10 cycles then high, evt_ready=1 -> one event with key=2, long=0; evt_valid high for exactly 1 cycle.
REQ-035 Key 0 low for 40 cycles then released -> event key=0, long=1.
REQ-036 Key 1 low for 2 cycles then high (bounce) -> no event; a 1-cycle high glitch during HELD -> a single event only.
REQ-037 Keys 0-3 complete in the same cycle, evt_ready=0 -> FIFO order 0,1,2,3 in consecutive cycles, overflow=0.
REQ-038 FIFO full with evt_ready=0 and key 3 pressed twice -> second completion sets overflow; after ready, the first key-3 event is delivered; clear_ovf -> overflow=0.
REQ-039 rst_n asserted during PRESS_DEB and during a pending event -> no event after release, all outputs 0.
